regfile_client: RTL and testbench
=================================

# regfile_client

Instruction sequencer that drives the read/write ports of the 8-entry register file. It accepts one three-operand operation per valid/ready handshake, then reads rs1/rs2 through the asynchronous read ports. It computes the result and writes it back through the synchronous write port. It sits between an upstream command source (pins or test driver) and the register file, as the initiator side of that interface.

## Interface
- WIDTH, 4: data width; must match the register file width.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset: asynchronous, active-high (asserted = 1).
- instr_valid  in  1  command present.
- instr_ready  out  1  block can accept a command; high only in IDLE.
- instr_op  in  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LI; 110 and 111 are illegal.
- instr_rd  in  3  destination register.
- instr_rs1, instr_rs2  in  3 each  source registers.
- instr_imm  in  WIDTH  immediate; used by LI only.
- rf_read_reg1, rf_read_reg2  out  3 each  register file read addresses.
- rf_read_data1, rf_read_data2  in  WIDTH each  register file read data; combinational from the addresses.
- rf_write_reg  out  3  write address.
- rf_write_data  out  WIDTH  write data.
- rf_we  out  1  write enable; one-cycle pulse.
- res_valid  out  1  one-cycle pulse when a command retires.
- res_data  out  WIDTH  computed result; held until the next retire.
- res_err  out  1  qualified by res_valid; high for an illegal op.

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, latch op/rd/rs1/rs2/imm and go to READ.
- READ:
  - rf_read_reg1=rs1 and rf_read_reg2=rs2 from the latched fields.
  - Latch rf_read_data1/2 into operand registers at the end of the cycle.
  - Go to EXEC.
- EXEC:
  - Compute from the latched operands into the result register.
  - Go to WRITE.
- WRITE:
  - rf_write_reg=rd and rf_write_data=result.
  - rf_we=1 only if the op is legal and rd!=0.
  - res_valid=1 and res_err=(op illegal).
  - Go to IDLE.
- Arithmetic:
  - ADD and SUB are modulo 2^WIDTH; carry and borrow are discarded (0xF+0x1=0x0, 0x0-0x1=0xF).
  - LI result = imm; its sources are still read and then ignored.
  - Illegal op: result = 0, no write, res_err=1.
- rd=0: the result is still computed and reported on res_data; rf_we stays 0. x0 remains zero without relying on the register file's own guard.
- rf_read_reg1/2, rf_write_reg, rf_write_data hold their last driven values outside their active states; only rf_we qualifies a write.
- instr_valid while not ready is ignored; the command must be held until accepted.
- Commands are serialized, so no read-after-write hazard exists: the next READ occurs at least one cycle after the previous write edge.

## Timing
- Reset values: state=IDLE, instr_ready=1, rf_we=0, res_valid=0, res_err=0, res_data=0, all address/data outputs 0, latched fields 0.
- Reset asserted mid-command aborts it: no rf_we and no res_valid are produced; the block returns to IDLE.
- Latency: handshake at edge N; READ in cycle N+1; EXEC in N+2; WRITE (rf_we, res_valid) in N+3; register file updated at edge N+4.
- instr_ready rises in cycle N+4, so the next accept is possible at edge N+4.
- Throughput: 1 command per 4 cycles.
- rf_we and res_valid are registered outputs (decoded from the state register, no input-to-output combinational path).

## Structure
- Package regfile_client_pkg holds:
  - the op encodings (OP_ADD..OP_LI);
  - the state enum (IDLE, READ, EXEC, WRITE);
  - the x0 address constant.
- Sub-module regfile_client_alu: combinational, inputs op/a/b/imm, outputs result and illegal. It is shared with future execute stages.
- Top level contains the FSM, the latches and the port muxing. The bench instantiates it together with the register file.

## Test plan
- Reset then LI r1,0x5: rf_we high in cycle N+3 with rf_write_reg=1 and rf_write_data=0x5; res_valid=1, res_err=0; reading r1 afterwards returns 0x5.
- LI r1,0xF; LI r2,0x1; ADD r3,r1,r2 -> r3=0x0 (wrap). Then SUB r4,r2,r1 -> r4=0x2.
- AND, OR, XOR r5,r1,r2 with r1=0xC and r2=0xA -> 0x8, 0xE, 0x6.
- ADD r0,r1,r2 -> res_valid=1 and res_data=sum, rf_we stays 0, r0 reads 0. Op 111 -> res_err=1, no rf_we.
- Back-to-back instr_valid held high: instr_ready is low for 3 cycles and each command is accepted exactly once every 4 cycles. Commands asserted while busy are not lost.
- Assert rst_n during EXEC of ADD r6 -> no rf_we and no res_valid; r6 is unchanged; instr_ready=1 the cycle after reset releases.

Source files
------------

// File: rtl/regfile_client_pkg.sv
// Shared encodings for the register-file client: op codes, sequencer states
// and the hard-wired zero register address.
package regfile_client_pkg;

  localparam int unsigned REG_AW = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LI  = 3'b101;

  localparam logic [REG_AW-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

endpackage : regfile_client_pkg

// File: rtl/regfile_client_alu.sv
// Combinational three-operand ALU; ADD/SUB wrap modulo 2^WIDTH and
// unknown op codes yield zero with the illegal flag raised.
module regfile_client_alu
  import regfile_client_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LI:   result = imm;
      default: illegal = 1'b1;
    endcase
  end

endmodule : regfile_client_alu

// File: rtl/regfile_client.sv
// Sequencer that accepts one command per handshake, reads both sources from
// the register file, executes in the ALU and writes the result back.
module regfile_client
  import regfile_client_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [2:0]        instr_rd,
  input  logic [2:0]        instr_rs1,
  input  logic [2:0]        instr_rs2,
  input  logic [WIDTH-1:0]  instr_imm,
  output logic [2:0]        rf_read_reg1,
  output logic [2:0]        rf_read_reg2,
  input  logic [WIDTH-1:0]  rf_read_data1,
  input  logic [WIDTH-1:0]  rf_read_data2,
  output logic [2:0]        rf_write_reg,
  output logic [WIDTH-1:0]  rf_write_data,
  output logic              rf_we,
  output logic              res_valid,
  output logic [WIDTH-1:0]  res_data,
  output logic              res_err
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       rd_q, rd_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [2:0]       rd_addr1_q, rd_addr1_d;
  logic [2:0]       rd_addr2_q, rd_addr2_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [2:0]       wr_reg_q, wr_reg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             we_q, we_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] alu_result;
  logic             alu_illegal;

  regfile_client_alu #(.WIDTH(WIDTH)) u_alu (
    .op      (op_q),
    .a       (opa_q),
    .b       (opb_q),
    .imm     (imm_q),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    rd_addr1_d = rd_addr1_q;
    rd_addr2_d = rd_addr2_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    wr_reg_d   = wr_reg_q;
    result_d   = result_q;
    we_d       = 1'b0;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          state_d    = READ;
          op_d       = instr_op;
          rd_d       = instr_rd;
          imm_d      = instr_imm;
          rd_addr1_d = instr_rs1;
          rd_addr2_d = instr_rs2;
        end
      end
      READ: begin
        opa_d   = rf_read_data1;
        opb_d   = rf_read_data2;
        state_d = EXEC;
      end
      EXEC: begin
        // Write-phase outputs are loaded here so they come straight from flops.
        result_d = alu_result;
        wr_reg_d = rd_q;
        we_d     = !alu_illegal && (rd_q != REG_X0);
        valid_d  = 1'b1;
        err_d    = alu_illegal;
        state_d  = WRITE;
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset here is active-high (rst_n = 1 asserts) and asynchronous.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      wr_reg_q   <= '0;
      result_q   <= '0;
      we_q       <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      rd_addr1_q <= rd_addr1_d;
      rd_addr2_q <= rd_addr2_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      wr_reg_q   <= wr_reg_d;
      result_q   <= result_d;
      we_q       <= we_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign instr_ready   = (state_q == IDLE);
  assign rf_read_reg1  = rd_addr1_q;
  assign rf_read_reg2  = rd_addr2_q;
  assign rf_write_reg  = wr_reg_q;
  assign rf_write_data = result_q;
  assign rf_we         = we_q;
  assign res_valid     = valid_q;
  assign res_data      = result_q;
  assign res_err       = err_q;

endmodule : regfile_client

// File: tb/tb_regfile_client.sv
// Directed bench: regfile_client driving an 8-entry register file with no
// built-in x0 guard, checked with immediate assertions at each step.
module tb_regfile_client;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             instr_valid;
  logic             instr_ready;
  logic [2:0]       instr_op;
  logic [2:0]       instr_rd;
  logic [2:0]       instr_rs1;
  logic [2:0]       instr_rs2;
  logic [WIDTH-1:0] instr_imm;
  logic [2:0]       rf_read_reg1;
  logic [2:0]       rf_read_reg2;
  logic [WIDTH-1:0] rf_read_data1;
  logic [WIDTH-1:0] rf_read_data2;
  logic [2:0]       rf_write_reg;
  logic [WIDTH-1:0] rf_write_data;
  logic             rf_we;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_err;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  logic [WIDTH-1:0] regs [8];

  regfile_client #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_rd      (instr_rd),
    .instr_rs1     (instr_rs1),
    .instr_rs2     (instr_rs2),
    .instr_imm     (instr_imm),
    .rf_read_reg1  (rf_read_reg1),
    .rf_read_reg2  (rf_read_reg2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .rf_we         (rf_we),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_err       (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Plain register file: no x0 guard, so r0 stays zero only if the client never writes it.
  initial for (int i = 0; i < 8; i++) regs[i] = '0;
  always @(posedge clk) if (rf_we) regs[rf_write_reg] <= rf_write_data;
  assign rf_read_data1 = regs[rf_read_reg1];
  assign rf_read_data2 = regs[rf_read_reg2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, instr_ready}, 32'd1);
  endtask

  // One command from handshake to retire; expected result is computed by the caller.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [WIDTH-1:0] imm, input logic [WIDTH-1:0] exp);
    logic exp_err;
    logic exp_we;
    exp_err = (op > 3'b101);
    exp_we  = !exp_err && (rd != 3'd0);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs1   = rs1;
    instr_rs2   = rs2;
    instr_imm   = imm;
    wait_ready({tag, "_accept"});
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check({tag, "_read_reg1"}, {29'd0, rf_read_reg1}, {29'd0, rs1});
    check({tag, "_read_reg2"}, {29'd0, rf_read_reg2}, {29'd0, rs2});
    check({tag, "_busy"}, {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_no_early_valid"}, {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_we"}, {31'd0, rf_we}, {31'd0, exp_we});
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
    check({tag, "_res_err"}, {31'd0, res_err}, {31'd0, exp_err});
    check({tag, "_res_data"}, {28'd0, res_data}, {28'd0, exp});
    check({tag, "_wr_reg"}, {29'd0, rf_write_reg}, {29'd0, rd});
    check({tag, "_wr_data"}, {28'd0, rf_write_data}, {28'd0, exp});
    @(negedge clk);
    check({tag, "_ready_back"}, {31'd0, instr_ready}, 32'd1);
    check({tag, "_valid_pulse"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    int last_acc;
    logic [2:0] b2b_rd  [3];
    logic [2:0] b2b_op  [3];
    logic [WIDTH-1:0] b2b_imm [3];

    rst_n       = 1'b1;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rd    = '0;
    instr_rs1   = '0;
    instr_rs2   = '0;
    instr_imm   = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_err", {31'd0, res_err}, 32'd0);
    check("rst_res_data", {28'd0, res_data}, 32'd0);
    check("rst_read_reg1", {29'd0, rf_read_reg1}, 32'd0);
    check("rst_wr_data", {28'd0, rf_write_data}, 32'd0);
    rst_n = 1'b0;

    run_cmd("li_r1_5", 3'b101, 3'd1, 3'd0, 3'd0, 4'h5, 4'h5);
    check("r1_is_5", {28'd0, regs[1]}, 32'h5);

    run_cmd("li_r1_f", 3'b101, 3'd1, 3'd2, 3'd3, 4'hF, 4'hF);
    run_cmd("li_r2_1", 3'b101, 3'd2, 3'd0, 3'd0, 4'h1, 4'h1);
    run_cmd("add_wrap", 3'b000, 3'd3, 3'd1, 3'd2, 4'h7, 4'h0);
    check("r3_wrap", {28'd0, regs[3]}, 32'h0);
    run_cmd("sub_r4", 3'b001, 3'd4, 3'd2, 3'd1, 4'h0, 4'h2);
    check("r4_is_2", {28'd0, regs[4]}, 32'h2);

    run_cmd("li_r1_c", 3'b101, 3'd1, 3'd0, 3'd0, 4'hC, 4'hC);
    run_cmd("li_r2_a", 3'b101, 3'd2, 3'd0, 3'd0, 4'hA, 4'hA);
    run_cmd("and_r5", 3'b010, 3'd5, 3'd1, 3'd2, 4'h0, 4'h8);
    check("r5_and", {28'd0, regs[5]}, 32'h8);
    run_cmd("or_r5", 3'b011, 3'd5, 3'd1, 3'd2, 4'h0, 4'hE);
    check("r5_or", {28'd0, regs[5]}, 32'hE);
    run_cmd("xor_r5", 3'b100, 3'd5, 3'd1, 3'd2, 4'h0, 4'h6);
    check("r5_xor", {28'd0, regs[5]}, 32'h6);

    run_cmd("add_r0", 3'b000, 3'd0, 3'd1, 3'd2, 4'h0, 4'h6);
    check("r0_zero", {28'd0, regs[0]}, 32'h0);
    run_cmd("illegal_op", 3'b111, 3'd5, 3'd1, 3'd2, 4'h3, 4'h0);
    check("r5_kept", {28'd0, regs[5]}, 32'h6);

    // Back-to-back: valid held high, next command presented right after each accept.
    b2b_op[0] = 3'b101; b2b_rd[0] = 3'd1; b2b_imm[0] = 4'h3;
    b2b_op[1] = 3'b101; b2b_rd[1] = 3'd2; b2b_imm[1] = 4'h4;
    b2b_op[2] = 3'b000; b2b_rd[2] = 3'd7; b2b_imm[2] = 4'h0;
    last_acc = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = b2b_op[0];
    instr_rd    = b2b_rd[0];
    instr_rs1   = 3'd1;
    instr_rs2   = 3'd2;
    instr_imm   = b2b_imm[0];
    for (int k = 0; k < 3; k++) begin
      wait_ready("b2b_accept");
      if (k > 0) check("b2b_spacing", cyc_cnt - last_acc, 32'd4);
      last_acc = cyc_cnt;
      @(posedge clk);
      #1;
      if (k < 2) begin
        instr_op  = b2b_op[k+1];
        instr_rd  = b2b_rd[k+1];
        instr_imm = b2b_imm[k+1];
      end else begin
        instr_valid = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("b2b_ready_low", {31'd0, instr_ready}, 32'd0);
      end
      check("b2b_retire", {31'd0, res_valid}, 32'd1);
      @(negedge clk);
    end
    check("b2b_r1", {28'd0, regs[1]}, 32'h3);
    check("b2b_r2", {28'd0, regs[2]}, 32'h4);
    check("b2b_r7", {28'd0, regs[7]}, 32'h7);

    // Reset during EXEC aborts the command without touching r6.
    run_cmd("li_r6_9", 3'b101, 3'd6, 3'd0, 3'd0, 4'h9, 4'h9);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = 3'b000;
    instr_rd    = 3'd6;
    instr_rs1   = 3'd1;
    instr_rs2   = 3'd2;
    wait_ready("abort_accept");
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_ready_in_rst", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    check("abort_no_we", {31'd0, rf_we}, 32'd0);
    check("abort_no_valid", {31'd0, res_valid}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready_after", {31'd0, instr_ready}, 32'd1);
    check("abort_no_valid_after", {31'd0, res_valid}, 32'd0);
    repeat (4) @(negedge clk);
    check("abort_r6_kept", {28'd0, regs[6]}, 32'h9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_client
